// File: rtl/fib_arbiter.sv
// Round-robin arbiter sharing one fib unit among NREQ requesters.
// Optional FIB_ARB_CACHE_EN adds a one-entry result cache that bypasses fib on a repeat index.
module fib_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned NW   = 5,
  parameter int unsigned FW   = 20
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*NW-1:0] req_n,
  output logic [NREQ-1:0]    done,
  output logic [FW-1:0]      f_out,
  output logic               busy,
  output logic               fib_start,
  output logic [NW-1:0]      fib_i,
  input  logic               fib_ready,
  input  logic               fib_done,
  input  logic [FW-1:0]      fib_f
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     id_q, id_d;
  logic [NW-1:0]     n_q, n_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [FW-1:0]     f_out_q, f_out_d;
  logic              busy_q, busy_d;
  logic              start_q, start_d;

  logic              grant_v;
  logic [IW-1:0]     grant_id;
  logic [IW-1:0]     scan_idx;
  logic [NW-1:0]     grant_n;

`ifdef FIB_ARB_CACHE_EN
  logic              cache_v_q, cache_v_d;
  logic [NW-1:0]     cache_n_q, cache_n_d;
  logic [FW-1:0]     cache_f_q, cache_f_d;
`endif

  // First set request scanning upward from ptr+1 with wrap
  always_comb begin
    grant_v  = 1'b0;
    grant_id = ptr_q;
    scan_idx = ptr_q;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      scan_idx = IW'((32'(ptr_q) + i) % NREQ);
      if (!grant_v && req[scan_idx]) begin
        grant_v  = 1'b1;
        grant_id = scan_idx;
      end
    end
    grant_n = req_n[32'(grant_id) * NW +: NW];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    n_d     = n_q;
    f_out_d = '0;
`ifdef FIB_ARB_CACHE_EN
    cache_v_d = cache_v_q;
    cache_n_d = cache_n_q;
    cache_f_d = cache_f_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (grant_v && fib_ready) begin
          id_d = grant_id;
          n_d  = grant_n;
`ifdef FIB_ARB_CACHE_EN
          if (cache_v_q && (grant_n == cache_n_q)) begin
            state_d = S_RESP;
            f_out_d = cache_f_q;
          end else begin
            state_d = S_START;
          end
`else
          state_d = S_START;
`endif
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (fib_done) begin
          state_d = S_RESP;
          f_out_d = fib_f;
`ifdef FIB_ARB_CACHE_EN
          cache_v_d = 1'b1;
          cache_n_d = n_q;
          cache_f_d = fib_f;
`endif
        end
      end
      S_RESP: begin
        ptr_d   = id_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered copies of what the next state implies
    done_d  = (state_d == S_RESP) ? (NREQ'(1) << id_d) : '0;
    busy_d  = (state_d != S_IDLE);
    start_d = (state_d == S_START);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ptr_q   <= IW'(NREQ - 1);
      id_q    <= '0;
      n_q     <= '0;
      done_q  <= '0;
      f_out_q <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
`ifdef FIB_ARB_CACHE_EN
      cache_v_q <= 1'b0;
      cache_n_q <= '0;
      cache_f_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      n_q     <= n_d;
      done_q  <= done_d;
      f_out_q <= f_out_d;
      busy_q  <= busy_d;
      start_q <= start_d;
`ifdef FIB_ARB_CACHE_EN
      cache_v_q <= cache_v_d;
      cache_n_q <= cache_n_d;
      cache_f_q <= cache_f_d;
`endif
    end
  end

  assign done      = done_q;
  assign f_out     = f_out_q;
  assign busy      = busy_q;
  assign fib_start = start_q;
  assign fib_i     = n_q;

endmodule

// File: tb/tb_fib_arbiter.sv
// Bench for fib_arbiter: behavioural fib unit plus a scoreboard of expected {done, f_out} pairs.
module tb_fib_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned NW   = 5;
  localparam int unsigned FW   = 20;

  logic               clk = 1'b0;
  logic               reset_n;
  logic [NREQ-1:0]    req;
  logic [NREQ*NW-1:0] req_n;
  logic [NREQ-1:0]    done;
  logic [FW-1:0]      f_out;
  logic               busy;
  logic               fib_start;
  logic [NW-1:0]      fib_i;
  logic               fib_ready;
  logic               fib_done;
  logic [FW-1:0]      fib_f;

  typedef struct packed {
    logic [NREQ-1:0] d;
    logic [FW-1:0]   f;
  } exp_t;

  exp_t sb[$];
  int   n_tests   = 0;
  int   n_fail    = 0;
  int   start_cnt = 0;
  int   start_ref;
  logic ready_block = 1'b0;

  // Behavioural fib unit: busy for n+3 cycles after start
  logic          fr;
  logic          fd;
  logic [FW-1:0] ff;
  logic [NW-1:0] nm;
  int            cnt;

  always #5 clk = ~clk;

  fib_arbiter #(.NREQ(NREQ), .NW(NW), .FW(FW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .req_n     (req_n),
    .done      (done),
    .f_out     (f_out),
    .busy      (busy),
    .fib_start (fib_start),
    .fib_i     (fib_i),
    .fib_ready (fib_ready),
    .fib_done  (fib_done),
    .fib_f     (fib_f)
  );

  function automatic logic [FW-1:0] fib_ref(input logic [NW-1:0] n);
    logic [FW-1:0] a, b, t;
    a = '0;
    b = FW'(1);
    for (int k = 0; k < int'(n); k++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      fr  <= 1'b1;
      fd  <= 1'b0;
      ff  <= '0;
      nm  <= '0;
      cnt <= 0;
    end else begin
      fd <= 1'b0;
      if (fib_start && fr) begin
        fr  <= 1'b0;
        nm  <= fib_i;
        cnt <= int'(fib_i) + 3;
      end else if (!fr) begin
        if (cnt == 1) begin
          fd <= 1'b1;
          ff <= fib_ref(nm);
          fr <= 1'b1;
        end
        cnt <= cnt - 1;
      end
    end
  end

  assign fib_ready = fr && !ready_block;
  assign fib_done  = fd;
  assign fib_f     = ff;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_n(input int k, input int n);
    req_n[k*NW +: NW] = NW'(n);
  endtask

  task automatic push_exp(input logic [NREQ-1:0] d, input logic [FW-1:0] f);
    exp_t e;
    e.d = d;
    e.f = f;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done !== '0) return;
    end
    check("done_timeout", 32'(done), 32'hFFFF_FFFF);
  endtask

  task automatic wait_start(input int budget);
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (fib_start === 1'b1) return;
    end
    check("start_timeout", 32'(fib_start), 32'd1);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset_n = 1'b0;
    req     = '0;
    sb.delete();
    repeat (cycles) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Scoreboard monitor; also models requesters dropping req after their done
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (fib_start === 1'b1) start_cnt++;
      if (done !== '0) begin
        if (sb.size() == 0) begin
          check("unexp_done", 32'(done), 32'd0);
        end else begin
          e = sb.pop_front();
          check("done", 32'(done), 32'(e.d));
          check("f_out", 32'(f_out), 32'(e.f));
        end
        req = req & ~done;
      end else if (f_out !== '0) begin
        check("f_out_idle", 32'(f_out), 32'd0);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    req     = '0;
    req_n   = '0;

    // 1: reset state and idle after release
    repeat (3) @(negedge clk);
    check("rst_done", 32'(done), 32'd0);
    check("rst_f_out", 32'(f_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start", 32'(fib_start), 32'd0);
    check("rst_fib_i", 32'(fib_i), 32'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_starts", 32'(start_cnt), 32'd0);

    // 2: single request n=10
    start_ref = start_cnt;
    set_n(0, 10);
    req[0] = 1'b1;
    push_exp(4'b0001, FW'(55));
    wait_start(10);
    check("t2_fib_i", 32'(fib_i), 32'd10);
    wait_done(40);
    @(negedge clk);
    check("t2_busy_drop", 32'(busy), 32'd0);
    check("t2_starts", 32'(start_cnt - start_ref), 32'd1);

    // 3: all four requesting from a fresh pointer
    do_reset(3);
    set_n(0, 0);
    set_n(1, 1);
    set_n(2, 20);
    set_n(3, 30);
    req = 4'b1111;
    push_exp(4'b0001, FW'(0));
    push_exp(4'b0010, FW'(1));
    push_exp(4'b0100, FW'(6765));
    push_exp(4'b1000, FW'(832040));
    for (int j = 0; j < 4; j++) wait_done(60);
    @(negedge clk);
    check("t3_req_clear", 32'(req), 32'd0);

    // 4: reset while waiting on fib abandons the job
    set_n(2, 20);
    req[2] = 1'b1;
    wait_start(10);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    req     = '0;
    sb.delete();
    repeat (2) @(negedge clk);
    check("t4_rst_busy", 32'(busy), 32'd0);
    check("t4_rst_done", 32'(done), 32'd0);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    check("t4_idle_busy", 32'(busy), 32'd0);
    set_n(2, 5);
    req[2] = 1'b1;
    push_exp(4'b0100, FW'(5));
    wait_done(40);

    // 5: repeat index from a different requester
    @(negedge clk);
    set_n(1, 10);
    req[1] = 1'b1;
    push_exp(4'b0010, FW'(55));
    wait_done(40);
    @(negedge clk);
    start_ref = start_cnt;
    set_n(3, 10);
    req[3] = 1'b1;
    push_exp(4'b1000, FW'(55));
`ifdef FIB_ARB_CACHE_EN
    @(negedge clk);
    check("t5_hit_done", 32'(done), 32'b1000);
    @(negedge clk);
    check("t5_hit_starts", 32'(start_cnt - start_ref), 32'd0);
`else
    wait_done(40);
    @(negedge clk);
    check("t5_miss_starts", 32'(start_cnt - start_ref), 32'd1);
`endif

    // 6: fib_ready low blocks the grant
    @(negedge clk);
    ready_block = 1'b1;
    start_ref   = start_cnt;
    set_n(0, 7);
    req[0] = 1'b1;
    push_exp(4'b0001, FW'(13));
    repeat (5) @(negedge clk);
    check("t6_blk_starts", 32'(start_cnt - start_ref), 32'd0);
    check("t6_blk_busy", 32'(busy), 32'd0);
    ready_block = 1'b0;
    @(negedge clk);
    check("t6_start", 32'(fib_start), 32'd1);
    check("t6_fib_i", 32'(fib_i), 32'd7);
    wait_done(40);

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
